// File: rtl/izh_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : izh_mon_pkg
//  Brief    : Shared types, default constants and helpers for the Izhikevich
//             spike monitor (detector state, threshold defaults, saturating
//             increment).
//  Revision : 1.0 - initial release
// ============================================================================
package izh_mon_pkg;

    // Spike detector states: waiting for a threshold crossing, or waiting
    // for the membrane voltage to fall back below the re-arm level.
    typedef enum logic [0:0] {
        ARMED   = 1'b0,
        REFRACT = 1'b1
    } det_state_t;

    localparam logic signed [7:0] C_THRESH_DEFAULT  = 8'sd19;
    localparam logic signed [7:0] C_REARM_DEFAULT   = 8'sd0;
    localparam int                C_TS_W_DEFAULT    = 16;
    localparam int                C_DEPTH_DEFAULT   = 8;
    localparam int                C_WIN_CYC_DEFAULT = 1024;

    // Increment that sticks at the all-ones value of a 'width'-bit field.
    // Operates on a 32-bit container; callers keep the low 'width' bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/izh_isi_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : izh_isi_fifo
//  Brief    : Synchronous first-word-fall-through FIFO holding inter-spike
//             intervals. A push on a full FIFO is accepted only when a pop
//             happens on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module izh_isi_fifo
    import izh_mon_pkg::*;
#(
    parameter int DATA_W = C_TS_W_DEFAULT,
    parameter int DEPTH  = C_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);

    localparam int             C_AW      = $clog2(DEPTH);
    localparam logic [C_AW:0]  C_PTR_ONE = (C_AW + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [C_AW:0]     r_wr_ptr;
    logic [C_AW:0]     r_rd_ptr;
    logic              w_do_pop;
    logic              w_do_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                       (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head_data = r_mem[r_rd_ptr[C_AW-1:0]];

    // Pointer update; a full FIFO with a pop frees the slot being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Storage; cleared on reset so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/izh_spike_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : izh_spike_monitor
//  Brief    : Spike detector with hysteresis re-arm for the Izhikevich neuron
//             core. Measures inter-spike intervals into a FWFT FIFO, keeps a
//             saturating spike count and a sticky overflow flag.
//             Optional windowed firing rate: define SPIKE_RATE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module izh_spike_monitor
    import izh_mon_pkg::*;
#(
    parameter logic signed [7:0] THRESH  = C_THRESH_DEFAULT,
    parameter logic signed [7:0] REARM   = C_REARM_DEFAULT,
    parameter int                TS_W    = C_TS_W_DEFAULT,   // 1..31
    parameter int                DEPTH   = C_DEPTH_DEFAULT,
    parameter int                WIN_CYC = C_WIN_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [7:0]      v_in,
    output logic            spike_o,
    output logic [15:0]     spike_cnt,
    output logic            isi_valid,
    output logic [TS_W-1:0] isi_data,
    input  logic            isi_ready,
    output logic            ovf,
    input  logic            ovf_clr,
    output logic [7:0]      rate_o,
    output logic            rate_stb
);

    det_state_t      r_state;
    logic            r_spike;
    logic [15:0]     r_spike_cnt;
    logic [TS_W-1:0] r_isi_cnt;
    logic            r_ovf;

    logic            w_above;
    logic            w_below;
    logic            w_spike;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_pop;
    logic            w_ovf_evt;
    logic [31:0]     w_isi_inc32;
    logic [31:0]     w_cnt_inc32;
    logic [TS_W-1:0] w_isi_inc;
    logic [15:0]     w_cnt_inc;
    logic            w_unused_hi;

    assign w_above = ($signed(v_in) > THRESH);
    assign w_below = ($signed(v_in) < REARM);
    assign w_spike = ena && (r_state == ARMED) && w_above;

    assign w_isi_inc32 = sat_inc(32'(r_isi_cnt), TS_W);
    assign w_cnt_inc32 = sat_inc(32'(r_spike_cnt), 16);
    assign w_isi_inc   = w_isi_inc32[TS_W-1:0];
    assign w_cnt_inc   = w_cnt_inc32[15:0];
    assign w_unused_hi = ^{w_isi_inc32[31:TS_W], w_cnt_inc32[31:16]};

    assign w_pop     = isi_valid && isi_ready;
    assign w_ovf_evt = w_spike && w_fifo_full && !w_pop;

    assign spike_o   = r_spike;
    assign spike_cnt = r_spike_cnt;
    assign isi_valid = !w_fifo_empty;
    assign ovf       = r_ovf;

    // Detector FSM with registered one-cycle spike pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARMED;
            r_spike <= 1'b0;
        end else begin
            r_spike <= 1'b0;
            if (ena) begin
                case (r_state)
                    ARMED: begin
                        if (w_above) begin
                            r_state <= REFRACT;
                            r_spike <= 1'b1;
                        end
                    end
                    REFRACT: begin
                        if (w_below) begin
                            r_state <= ARMED;
                        end
                    end
                    default: r_state <= ARMED;
                endcase
            end
        end
    end

    // Interval counter: counts enabled cycles, restarts after each spike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isi_cnt <= '0;
        end else if (ena) begin
            r_isi_cnt <= w_spike ? '0 : w_isi_inc;
        end
    end

    // Total spike count, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_cnt <= '0;
        end else if (w_spike) begin
            r_spike_cnt <= w_cnt_inc;
        end
    end

    // Sticky overflow; a new drop outranks a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // The pushed interval includes the spike cycle itself.
    izh_isi_fifo #(
        .DATA_W (TS_W),
        .DEPTH  (DEPTH)
    ) u_isi_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_spike),
        .push_data (w_isi_inc),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head_data (isi_data)
    );

`ifdef SPIKE_RATE_EN
    localparam int                 C_WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [C_WIN_W-1:0] C_WIN_LAST = C_WIN_W'(WIN_CYC - 1);
    localparam logic [C_WIN_W-1:0] C_WIN_ONE  = C_WIN_W'(1);

    logic [C_WIN_W-1:0] r_win_cnt;
    logic [7:0]         r_acc;
    logic [7:0]         r_rate;
    logic               r_rate_stb;
    logic [31:0]        w_acc_inc32;
    logic [7:0]         w_acc_next;
    logic               w_unused_acc_hi;

    assign w_acc_inc32     = sat_inc(32'(r_acc), 8);
    assign w_acc_next      = w_spike ? w_acc_inc32[7:0] : r_acc;
    assign w_unused_acc_hi = ^w_acc_inc32[31:8];
    assign rate_o          = r_rate;
    assign rate_stb        = r_rate_stb;

    // Window of WIN_CYC enabled cycles; a spike on the last cycle is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt  <= '0;
            r_acc      <= '0;
            r_rate     <= '0;
            r_rate_stb <= 1'b0;
        end else begin
            r_rate_stb <= 1'b0;
            if (ena) begin
                if (r_win_cnt == C_WIN_LAST) begin
                    r_win_cnt  <= '0;
                    r_acc      <= '0;
                    r_rate     <= w_acc_next;
                    r_rate_stb <= 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + C_WIN_ONE;
                    r_acc     <= w_acc_next;
                end
            end
        end
    end
`else
    logic w_unused_win_cfg;

    assign w_unused_win_cfg = (WIN_CYC > 0);
    assign rate_o           = '0;
    assign rate_stb         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_izh_spike_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_izh_spike_monitor
//  Brief    : Self-checking bench for izh_spike_monitor: table-driven detector
//             vectors plus ISI scoreboard, overflow, enable-gap, reset and
//             rate-window sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_izh_spike_monitor;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  v_in;
    logic        spike_o;
    logic [15:0] spike_cnt;
    logic        isi_valid;
    logic [15:0] isi_data;
    logic        isi_ready;
    logic        ovf;
    logic        ovf_clr;
    logic [7:0]  rate_o;
    logic        rate_stb;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_armed;
    int m_isi;
    int m_cnt;
    bit m_ovf;
    int m_win;
    int m_acc;
    int m_rate;
    int m_stb;
    int isi_q[$];
    int last_pop;

    typedef struct {
        logic              en;
        logic signed [7:0] v;
        logic              exp_spk;
    } vec_t;

    vec_t vecs [19];

    izh_spike_monitor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .v_in      (v_in),
        .spike_o   (spike_o),
        .spike_cnt (spike_cnt),
        .isi_valid (isi_valid),
        .isi_data  (isi_data),
        .isi_ready (isi_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .rate_o    (rate_o),
        .rate_stb  (rate_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_spike_o"},   spike_o,   0);
        chk({tag, "_spike_cnt"}, spike_cnt, 0);
        chk({tag, "_isi_valid"}, isi_valid, 0);
        chk({tag, "_isi_data"},  isi_data,  0);
        chk({tag, "_ovf"},       ovf,       0);
        chk({tag, "_rate_o"},    rate_o,    0);
        chk({tag, "_rate_stb"},  rate_stb,  0);
    endtask

    // Asserts reset between edges (checks the asynchronous clear), holds it
    // across an edge, then releases it and clears the model.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        ena       = 1'b0;
        isi_ready = 1'b0;
        ovf_clr   = 1'b0;
        v_in      = 8'hBF;
        #1;
        check_reset_vals("rst_async");
        @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        rst_n   = 1'b1;
        m_armed = 1'b1;
        m_isi   = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_win   = 0;
        m_acc   = 0;
        m_rate  = 0;
        m_stb   = 0;
        isi_q.delete();
    endtask

    // One clock cycle: drive inputs, score the pop, update the model, then
    // compare the registered outputs after the edge.
    task automatic cyc(input logic e, input logic signed [7:0] v,
                       input logic rdy, input logic clr);
        bit spk;
        bit evt;
        int val;
        ena       = e;
        v_in      = v;
        isi_ready = rdy;
        ovf_clr   = clr;
        chk("isi_valid", isi_valid, (isi_q.size() > 0) ? 1 : 0);
        if (rdy && isi_q.size() > 0) begin
            chk("isi_data", isi_data, isi_q[0]);
            last_pop = int'(isi_data);
            void'(isi_q.pop_front());
        end
        spk = e && m_armed && (v > 8'sd19);
        evt = 1'b0;
        if (e) begin
            if (spk) begin
                val = (m_isi >= 65535) ? 65535 : m_isi + 1;
                if (isi_q.size() < 8) isi_q.push_back(val);
                else evt = 1'b1;
                m_isi   = 0;
                m_armed = 1'b0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                if (m_isi < 65535) m_isi++;
                if (!m_armed && v < 8'sd0) m_armed = 1'b1;
            end
        end
        if (evt) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
`ifdef SPIKE_RATE_EN
        m_stb = 0;
        if (e) begin
            if (m_win == 1023) begin
                m_rate = (m_acc + int'(spk) > 255) ? 255 : m_acc + int'(spk);
                m_stb  = 1;
                m_acc  = 0;
                m_win  = 0;
            end else begin
                m_win++;
                if (spk && m_acc < 255) m_acc++;
            end
        end
`endif
        @(posedge clk);
        #1;
        chk("spike_o",   spike_o,   spk ? 1 : 0);
        chk("spike_cnt", spike_cnt, m_cnt);
        chk("ovf",       ovf,       m_ovf ? 1 : 0);
        chk("rate_o",    rate_o,    m_rate);
        chk("rate_stb",  rate_stb,  m_stb);
    endtask

    initial begin
        int n;
        rst_n     = 1'b1;
        ena       = 1'b0;
        v_in      = 8'hBF;
        isi_ready = 1'b0;
        ovf_clr   = 1'b0;
        last_pop  = 0;

        // Detector vectors: ramp, hold above threshold, re-arm, second spike
        vecs[0] = '{1'b1, -8'sd70, 1'b0};
        vecs[1] = '{1'b1, -8'sd40, 1'b0};
        vecs[2] = '{1'b1, -8'sd10, 1'b0};
        vecs[3] = '{1'b1,  8'sd10, 1'b0};
        vecs[4] = '{1'b1,  8'sd19, 1'b0};
        vecs[5] = '{1'b1,  8'sd25, 1'b1};
        for (int i = 6; i < 16; i++) vecs[i] = '{1'b1, 8'sd25, 1'b0};
        vecs[16] = '{1'b1, -8'sd65, 1'b0};
        vecs[17] = '{1'b1,  8'sd25, 1'b1};
        vecs[18] = '{1'b1, -8'sd65, 1'b0};

        do_reset();

        // Threshold / hysteresis table
        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].en, vecs[i].v, 1'b0, 1'b0);
            chk("tbl_spike", spike_o, vecs[i].exp_spk);
            if (i == 15) chk("tbl_cnt_after_hold", spike_cnt, 1);
        end
        chk("tbl_cnt_final", spike_cnt, 2);

        // Spikes at enabled cycles 100 and 150
        do_reset();
        for (int i = 1; i <= 150; i++) begin
            cyc(1'b1, (i == 100 || i == 150) ? 8'sd25 : -8'sd65, 1'b0, 1'b0);
        end
        chk("isi_head_100", isi_data, 100);
        cyc(1'b1, -8'sd65, 1'b1, 1'b0);
        chk("isi_head_50", isi_data, 50);
        cyc(1'b1, -8'sd65, 1'b1, 1'b0);
        chk("isi_empty_after_pops", isi_valid, 0);

        // Nine spikes into an eight-deep FIFO with no consumer
        do_reset();
        for (int s = 0; s < 9; s++) begin
            for (int g = 0; g < s + 3; g++) cyc(1'b1, -8'sd65, 1'b0, 1'b0);
            cyc(1'b1, 8'sd25, 1'b0, 1'b0);
        end
        chk("ovf_set", ovf, 1);
        chk("cnt_9", spike_cnt, 9);
        chk("ovf_head_oldest", isi_data, 4);
        cyc(1'b1, -8'sd65, 1'b0, 1'b1);
        chk("ovf_cleared", ovf, 0);

        // Full FIFO, spike coinciding with a pop
        cyc(1'b1, -8'sd65, 1'b0, 1'b0);
        cyc(1'b1, -8'sd65, 1'b0, 1'b0);
        cyc(1'b1, 8'sd25, 1'b1, 1'b0);
        chk("full_pop_no_ovf", ovf, 0);
        n = 1;
        for (int k = 0; k < 20 && isi_valid; k++) begin
            cyc(1'b1, -8'sd65, 1'b1, 1'b0);
            n++;
        end
        chk("full_pop_entries", n, 9);
        chk("full_pop_newest_last", last_pop, 4);

        // Enable gap between spikes 40 enabled cycles apart
        do_reset();
        cyc(1'b1, -8'sd65, 1'b0, 1'b0);
        cyc(1'b1, 8'sd25, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, -8'sd65, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 8'sd25, 1'b0, 1'b0);
        chk("ena_low_no_spike", spike_cnt, 1);
        for (int i = 0; i < 19; i++) cyc(1'b1, -8'sd65, 1'b0, 1'b0);
        cyc(1'b1, 8'sd25, 1'b0, 1'b0);
        chk("ena_first_isi", isi_data, 2);
        cyc(1'b1, -8'sd65, 1'b1, 1'b0);
        chk("ena_isi_40", isi_data, 40);
        cyc(1'b1, 8'sd25, 1'b0, 1'b0);

        // Reset asserted mid-stream (checked between edges inside do_reset)
        do_reset();

        // Rate window: seven spikes within the first 1024 enabled cycles
        for (int i = 1; i <= 1030; i++) begin
            cyc(1'b1, ((i % 100) == 50 && i <= 700) ? 8'sd25 : -8'sd65, 1'b1, 1'b0);
            if (i == 1024) begin
`ifdef SPIKE_RATE_EN
                chk("rate_stb_1024", rate_stb, 1);
                chk("rate_7", rate_o, 7);
`else
                chk("rate_stb_off", rate_stb, 0);
                chk("rate_off", rate_o, 0);
`endif
            end
        end
        chk("rate_spikes_7", spike_cnt, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
